// File: rtl/phy_rx_link_ctrl.sv
// phy_rx_link_ctrl
//   Link-sync controller and word assembler behind the two-lane PHY RX
//   deserialisers. It hunts for COM alignment on both lanes and declares bus
//   sync. Once synced, it strips COM/IDL control pairs and packs data byte
//   pairs into 32-bit words. Sync is dropped after repeated lane mismatches.
//
// Ports
//   clk_4f          in   byte clock, rising edge
//   reset           in   synchronous, active-high
//   lane_valid      in   lane bytes valid this cycle (0 = stall, state held)
//   lane0_byte      in   [7:0] lane 0 byte (even byte positions)
//   lane1_byte      in   [7:0] lane 1 byte (odd byte positions)
//   data_out        out  [31:0] assembled word, holds between words
//   valid_out       out  1-cycle pulse, data_out valid
//   sincronizar_bus out  1 while SYNCED
//   frame_err       out  1-cycle pulse on mismatch or half-word discard
//   state_out       out  [1:0] 00 SEARCH, 01 LOCKING, 10 SYNCED
module phy_rx_link_ctrl #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4,
  parameter logic [7:0]  COM      = 8'hBC,
  parameter logic [7:0]  IDL      = 8'h7C
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        lane_valid,
  input  logic [7:0]  lane0_byte,
  input  logic [7:0]  lane1_byte,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        sincronizar_bus,
  output logic        frame_err,
  output logic [1:0]  state_out
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    LOCKING = 2'b01,
    SYNCED  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    C_COMP,
    C_IDLP,
    C_DATA,
    C_MISM
  } class_t;

  state_t        state, state_d;
  class_t        cls;
  logic [LW-1:0] lock_cnt, lock_d;
  logic [SW-1:0] loss_cnt, loss_d;
  logic          half, half_d;
  logic [15:0]   low_word, low_d;
  logic [31:0]   word_buf, buf_d;
  logic          word_pend, pend_d;
  logic          ferr_d;
  logic          ctl0, ctl1;

  assign ctl0 = (lane0_byte == COM) || (lane0_byte == IDL);
  assign ctl1 = (lane1_byte == COM) || (lane1_byte == IDL);

  always_comb begin
    cls = C_MISM;
    if ((lane0_byte == COM) && (lane1_byte == COM))
      cls = C_COMP;
    else if ((lane0_byte == IDL) && (lane1_byte == IDL))
      cls = C_IDLP;
    else if (!ctl0 && !ctl1)
      cls = C_DATA;
  end

  always_comb begin
    state_d = state;
    lock_d  = lock_cnt;
    loss_d  = loss_cnt;
    half_d  = half;
    low_d   = low_word;
    buf_d   = word_buf;
    pend_d  = 1'b0;
    ferr_d  = 1'b0;
    if (lane_valid) begin
      case (state)
        SEARCH: begin
          if (cls == C_COMP) begin
            if (LOCK_CNT == 1) begin
              state_d = SYNCED;
              lock_d  = '0;
              loss_d  = '0;
              half_d  = 1'b0;
            end else begin
              state_d = LOCKING;
              lock_d  = LW'(1);
            end
          end
        end
        LOCKING: begin
          if (cls == C_COMP) begin
            if (32'(lock_cnt) + 32'd1 >= LOCK_CNT) begin
              state_d = SYNCED;
              lock_d  = '0;
              loss_d  = '0;
              half_d  = 1'b0;
            end else begin
              lock_d = lock_cnt + LW'(1);
            end
          end else begin
            state_d = SEARCH;
            lock_d  = '0;
          end
        end
        SYNCED: begin
          case (cls)
            C_COMP, C_IDLP: begin
              loss_d = '0;
              // A control pair splitting a word discards the pending half.
              if (half) begin
                half_d = 1'b0;
                ferr_d = 1'b1;
              end
            end
            C_DATA: begin
              loss_d = '0;
              if (!half) begin
                low_d  = {lane1_byte, lane0_byte};
                half_d = 1'b1;
              end else begin
                // Word is staged here and presented one edge later.
                buf_d  = {lane1_byte, lane0_byte, low_word};
                pend_d = 1'b1;
                half_d = 1'b0;
              end
            end
            default: begin
              ferr_d = 1'b1;
              half_d = 1'b0;
              if (32'(loss_cnt) + 32'd1 >= LOSS_CNT) begin
                state_d = SEARCH;
                lock_d  = '0;
                loss_d  = '0;
              end else begin
                loss_d = loss_cnt + SW'(1);
              end
            end
          endcase
        end
        default: begin
          state_d = SEARCH;
          lock_d  = '0;
          loss_d  = '0;
          half_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= SEARCH;
      lock_cnt  <= '0;
      loss_cnt  <= '0;
      half      <= 1'b0;
      low_word  <= '0;
      word_buf  <= '0;
      word_pend <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      lock_cnt  <= lock_d;
      loss_cnt  <= loss_d;
      half      <= half_d;
      low_word  <= low_d;
      word_buf  <= buf_d;
      word_pend <= pend_d;
      if (word_pend)
        data_out <= word_buf;
      valid_out <= word_pend;
      frame_err <= ferr_d;
    end
  end

  assign state_out       = state;
  assign sincronizar_bus = (state == SYNCED);

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb_phy_rx_link_ctrl
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the link controller.
module tb_phy_rx_link_ctrl;

  localparam int unsigned LOCK = 4;
  localparam int unsigned LOSS = 4;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic        lane_valid = 1'b0;
  logic [7:0]  lane0_byte = '0;
  logic [7:0]  lane1_byte = '0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        sincronizar_bus;
  logic        frame_err;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  phy_rx_link_ctrl #(
    .LOCK_CNT(LOCK),
    .LOSS_CNT(LOSS),
    .COM(8'hBC),
    .IDL(8'h7C)
  ) dut (
    .clk_4f(clk_4f),
    .reset(reset),
    .lane_valid(lane_valid),
    .lane0_byte(lane0_byte),
    .lane1_byte(lane1_byte),
    .data_out(data_out),
    .valid_out(valid_out),
    .sincronizar_bus(sincronizar_bus),
    .frame_err(frame_err),
    .state_out(state_out)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: mode 0 search, 1 locking, 2 synced.
  int          m_mode = 0;
  int          m_lock = 0;
  int          m_loss = 0;
  logic [15:0] m_pend[$];
  logic [31:0] m_emit[$];
  logic [31:0] m_data = '0;
  bit          m_valid = 0;
  bit          m_ferr = 0;

  function automatic void model_step(bit r, bit v, logic [7:0] b0, logic [7:0] b1);
    bit com_pair, idl_pair, data_pair;
    if (r) begin
      m_mode = 0; m_lock = 0; m_loss = 0;
      m_pend.delete(); m_emit.delete();
      m_data = '0; m_valid = 0; m_ferr = 0;
      return;
    end
    m_valid = 0;
    m_ferr  = 0;
    if (m_emit.size() > 0) begin
      m_data  = m_emit.pop_front();
      m_valid = 1;
    end
    if (!v) return;
    com_pair  = (b0 == 8'hBC) && (b1 == 8'hBC);
    idl_pair  = (b0 == 8'h7C) && (b1 == 8'h7C);
    data_pair = !(b0 inside {8'hBC, 8'h7C}) && !(b1 inside {8'hBC, 8'h7C});
    if (m_mode == 0) begin
      if (com_pair) begin
        m_lock = 1;
        m_mode = (m_lock >= LOCK) ? 2 : 1;
        if (m_mode == 2) m_lock = 0;
      end
    end else if (m_mode == 1) begin
      if (com_pair) begin
        m_lock++;
        if (m_lock >= LOCK) begin m_mode = 2; m_lock = 0; m_loss = 0; end
      end else begin
        m_mode = 0; m_lock = 0;
      end
    end else begin
      if (data_pair) begin
        m_loss = 0;
        m_pend.push_back({b1, b0});
        if (m_pend.size() == 2) begin
          m_emit.push_back({m_pend[1], m_pend[0]});
          m_pend.delete();
        end
      end else if (com_pair || idl_pair) begin
        m_loss = 0;
        if (m_pend.size() != 0) begin m_ferr = 1; m_pend.delete(); end
      end else begin
        m_ferr = 1;
        m_pend.delete();
        m_loss++;
        if (m_loss >= LOSS) begin m_mode = 0; m_loss = 0; m_lock = 0; end
      end
    end
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [7:0] b0, input logic [7:0] b1);
    reset = r; lane_valid = v; lane0_byte = b0; lane1_byte = b1;
    @(posedge clk_4f);
    #1;
    model_step(r, v, b0, b1);
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'hBC || b == 8'h7C) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic lock_up();
    for (int i = 0; i < int'(LOCK); i++) cycle(0, 1, 8'hBC, 8'hBC);
  endtask

  task automatic test_reset();
    cycle(1, 1, 8'($urandom), 8'($urandom));
    cycle(1, 1, 8'hBC, 8'hBC);
    checks++;
    if (state_out !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state_out); end
    checks++;
    if (sincronizar_bus !== 1'b0 || valid_out !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got sync=%b valid=%b ferr=%b exp 0 0 0", sincronizar_bus, valid_out, frame_err);
    end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", data_out); end
  endtask

  task automatic test_lock();
    logic [1:0] exp_st[4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'hBC, 8'hBC);
      checks++;
      if (state_out !== exp_st[i]) begin
        errors++; $display("FAIL lock_state%0d got %b exp %b", i, state_out, exp_st[i]);
      end
    end
    checks++;
    if (sincronizar_bus !== 1'b1) begin errors++; $display("FAIL lock_sync got %b exp 1", sincronizar_bus); end
  endtask

  task automatic test_word();
    cycle(0, 1, 8'h11, 8'h22);
    cycle(0, 1, 8'h33, 8'h44);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL word_early_valid got %b exp 0", valid_out); end
    cycle(0, 1, 8'h7C, 8'h7C);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin
      errors++; $display("FAIL word_out got valid=%b data=%h exp 1 44332211", valid_out, data_out);
    end
    cycle(0, 1, 8'h7C, 8'h7C);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h44332211) begin
      errors++; $display("FAIL word_hold got valid=%b data=%h exp 0 44332211", valid_out, data_out);
    end
  endtask

  task automatic test_idle_discard();
    int pulses = 0;
    cycle(0, 1, 8'h11, 8'h22);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL idl_first_ferr got %b exp 0", frame_err); end
    cycle(0, 1, 8'h7C, 8'h7C);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL idl_ferr got %b exp 1", frame_err); end
    cycle(0, 1, 8'h55, 8'h66);
    pulses += int'(valid_out);
    cycle(0, 1, 8'h77, 8'h88);
    pulses += int'(valid_out);
    cycle(0, 1, 8'h7C, 8'h7C);
    pulses += int'(valid_out);
    checks++;
    if (data_out !== 32'h88776655) begin errors++; $display("FAIL idl_word got %h exp 88776655", data_out); end
    cycle(0, 1, 8'h7C, 8'h7C);
    pulses += int'(valid_out);
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL idl_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_loss();
    logic [1:0] exp_st[4] = '{2'b10, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'hBC, 8'h00);
      checks++;
      if (frame_err !== 1'b1 || state_out !== exp_st[i]) begin
        errors++; $display("FAIL loss%0d got ferr=%b st=%b exp 1 %b", i, frame_err, state_out, exp_st[i]);
      end
    end
    checks++;
    if (sincronizar_bus !== 1'b0) begin errors++; $display("FAIL loss_sync got %b exp 0", sincronizar_bus); end
  endtask

  task automatic test_lock_abort_stall();
    cycle(1, 0, 8'h00, 8'h00);
    cycle(0, 1, 8'hBC, 8'hBC);
    cycle(0, 1, 8'hBC, 8'hBC);
    checks++;
    if (state_out !== 2'b01) begin errors++; $display("FAIL abort_locking got %b exp 01", state_out); end
    cycle(0, 1, 8'h11, 8'h22);
    checks++;
    if (state_out !== 2'b00) begin errors++; $display("FAIL abort_search got %b exp 00", state_out); end
    lock_up();
    cycle(0, 1, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 8'hBC, 8'h00);
      checks++;
      if (valid_out !== 1'b0 || frame_err !== 1'b0 || state_out !== 2'b10) begin
        errors++; $display("FAIL stall%0d got valid=%b ferr=%b st=%b exp 0 0 10", i, valid_out, frame_err, state_out);
      end
    end
    cycle(0, 1, 8'h33, 8'h44);
    cycle(0, 1, 8'h7C, 8'h7C);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin
      errors++; $display("FAIL stall_word got valid=%b data=%h exp 1 44332211", valid_out, data_out);
    end
  endtask

  task automatic test_reset_midword();
    int pulses = 0;
    cycle(0, 1, 8'hA1, 8'hA2);
    cycle(1, 1, 8'hA3, 8'hA4);
    pulses += int'(valid_out);
    cycle(0, 1, 8'h55, 8'h66);
    pulses += int'(valid_out);
    cycle(0, 1, 8'h77, 8'h88);
    pulses += int'(valid_out);
    cycle(0, 1, 8'h7C, 8'h7C);
    pulses += int'(valid_out);
    checks++;
    if (pulses != 0 || state_out !== 2'b00 || data_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid got pulses=%0d st=%b data=%h exp 0 00 00000000", pulses, state_out, data_out);
    end
    for (int i = 0; i < int'(LOCK) - 1; i++) cycle(0, 1, 8'hBC, 8'hBC);
    checks++;
    if (sincronizar_bus !== 1'b0) begin errors++; $display("FAIL rst_relock_early got %b exp 0", sincronizar_bus); end
    cycle(0, 1, 8'hBC, 8'hBC);
    cycle(0, 1, 8'h12, 8'h34);
    cycle(0, 1, 8'h56, 8'h78);
    cycle(0, 1, 8'hBC, 8'hBC);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h78563412) begin
      errors++; $display("FAIL rst_relock_word got valid=%b data=%h exp 1 78563412", valid_out, data_out);
    end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1;
    int sel;
    bit r, v;
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 25) begin b0 = 8'hBC; b1 = 8'hBC; end
      else if (sel < 35) begin b0 = 8'h7C; b1 = 8'h7C; end
      else if (sel < 85) begin b0 = rand_data(); b1 = rand_data(); end
      else if (sel < 90) begin b0 = 8'hBC; b1 = rand_data(); end
      else if (sel < 95) begin b0 = rand_data(); b1 = 8'h7C; end
      else begin b0 = 8'h7C; b1 = 8'hBC; end
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 85);
      cycle(r, v, b0, b1);
      checks++;
      if (state_out !== 2'(m_mode) || sincronizar_bus !== (m_mode == 2)) begin
        errors++; $display("FAIL rnd_state@%0d got st=%b sync=%b exp %0d", n, state_out, sincronizar_bus, m_mode);
      end
      checks++;
      if (valid_out !== m_valid || frame_err !== m_ferr) begin
        errors++; $display("FAIL rnd_pulse@%0d got valid=%b ferr=%b exp %b %b", n, valid_out, frame_err, m_valid, m_ferr);
      end
      checks++;
      if (data_out !== m_data) begin
        errors++; $display("FAIL rnd_data@%0d got %h exp %h", n, data_out, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_word();
    test_idle_discard();
    test_loss();
    test_lock_abort_stall();
    test_reset_midword();
    cycle(1, 0, 8'h00, 8'h00);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
